// File: rtl/vertex_assembler.sv
// vertex_assembler: gathers the converter's serial integer stream into
// (X, Y, Z) triples, clamps X/Y to the screen, computes the linear
// framebuffer address, and queues finished vertices in a small
// first-word-fall-through FIFO for the rasterizer.
//
// Ports:
//   clk_in, rst_n_in    clock (rising edge), async active-low reset
//   data_valid_in       int_value_in carries a word this cycle
//   int_value_in        signed 16-bit word; phase order X, Y, Z
//   frame_start_in      restart word phase, clear overflow and count
//   ready_in            rasterizer takes the head vertex this cycle
//   valid_out           FIFO non-empty
//   x_out/y_out/z_out   head vertex (clamped X/Y, raw Z)
//   addr_out            y_out*SCREEN_W + x_out, truncated to ADDR_W
//   clipped_out         head vertex had X or Y clamped
//   overflow_out        sticky: a vertex was dropped on a full FIFO
//   vertex_count_out    vertices written since frame start, saturating
module vertex_assembler #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 180,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              data_valid_in,
  input  logic [15:0]       int_value_in,
  input  logic              frame_start_in,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [15:0]       x_out,
  output logic [15:0]       y_out,
  output logic [15:0]       z_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              clipped_out,
  output logic              overflow_out,
  output logic [15:0]       vertex_count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic [15:0]       x;
    logic [15:0]       y;
    logic [15:0]       z;
    logic [ADDR_W-1:0] addr;
    logic              clip;
  } vtx_t;

  function automatic logic [15:0] clamp(input logic [15:0] v, input int hi);
    if ($signed(v) < 0)             return 16'd0;
    else if (int'($signed(v)) > hi) return 16'(hi);
    else                            return v;
  endfunction

  // ---------------- word assembly ----------------
  logic [1:0]  phase;
  logic [15:0] xh, yh;
  // vld_pipe[0]: raw triple captured, vld_pipe[1]: clamped vertex ready to push
  logic [1:0]  vld_pipe;
  logic [15:0] rx, ry, rz;
  vtx_t        cmp;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase       <= 2'd0;
      xh          <= '0;
      yh          <= '0;
      vld_pipe[0] <= 1'b0;
      rx          <= '0;
      ry          <= '0;
      rz          <= '0;
    end else begin
      // a Z word coinciding with frame start is taken as the new frame's X
      vld_pipe[0] <= data_valid_in && (phase == 2'd2) && !frame_start_in;
      if (frame_start_in) begin
        if (data_valid_in) begin
          xh    <= int_value_in;
          phase <= 2'd1;
        end else begin
          phase <= 2'd0;
        end
      end else if (data_valid_in) begin
        case (phase)
          2'd0:    begin xh <= int_value_in; phase <= 2'd1; end
          2'd1:    begin yh <= int_value_in; phase <= 2'd2; end
          default: begin
            rx    <= xh;
            ry    <= yh;
            rz    <= int_value_in;
            phase <= 2'd0;
          end
        endcase
      end
    end
  end

  // ---------------- compute stage ----------------
  logic [15:0]       cx, cy;
  logic [ADDR_W-1:0] caddr;

  always_comb begin
    cx    = clamp(rx, SCREEN_W - 1);
    cy    = clamp(ry, SCREEN_H - 1);
    caddr = ADDR_W'(cy) * ADDR_W'(SCREEN_W) + ADDR_W'(cx);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe[1] <= 1'b0;
      cmp         <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) cmp <= '{x: cx, y: cy, z: rz, addr: caddr,
                                clip: (cx != rx) || (cy != ry)};
    end
  end

  // ---------------- output FIFO ----------------
  vtx_t          mem [DEPTH];
  logic [AW-1:0] wp, rp, hidx;
  logic [OW-1:0] occ;
  logic          empty, full, pop, push, drop;

  always_comb begin
    empty = (occ == '0);
    full  = (occ == OW'(DEPTH));
    pop   = !empty && ready_in;
    push  = vld_pipe[1] && (!full || pop);
    drop  = vld_pipe[1] && full && !pop;
    // when empty, show the most recently popped slot so outputs hold;
    // that slot cannot be rewritten until the FIFO wraps through it
    hidx  = empty ? rp - AW'(1) : rp;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp               <= '0;
      rp               <= '0;
      occ              <= '0;
      overflow_out     <= 1'b0;
      vertex_count_out <= '0;
    end else begin
      if (push) begin
        mem[wp] <= cmp;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      occ <= occ + OW'(push) - OW'(pop);
      if (frame_start_in) begin
        overflow_out     <= 1'b0;
        vertex_count_out <= '0;
      end else begin
        if (drop) overflow_out <= 1'b1;
        if (push && vertex_count_out != 16'hFFFF)
          vertex_count_out <= vertex_count_out + 16'd1;
      end
    end
  end

  assign valid_out   = !empty;
  assign x_out       = mem[hidx].x;
  assign y_out       = mem[hidx].y;
  assign z_out       = mem[hidx].z;
  assign addr_out    = mem[hidx].addr;
  assign clipped_out = mem[hidx].clip;

endmodule

// File: tb/tb_vertex_assembler.sv
// Self-checking bench for vertex_assembler: directed scenarios plus a
// randomized stream checked against a triple-level arithmetic model.
module tb_vertex_assembler;

  localparam int SW = 320;
  localparam int SH = 180;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        data_valid_in = 1'b0;
  logic [15:0] int_value_in = '0;
  logic        frame_start_in = 1'b0;
  logic        ready_in = 1'b0;
  logic        valid_out;
  logic [15:0] x_out, y_out, z_out, addr_out, vertex_count_out;
  logic        clipped_out, overflow_out;

  int n_cmp = 0;
  int n_err = 0;

  vertex_assembler dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_valid_in(data_valid_in),
    .int_value_in(int_value_in), .frame_start_in(frame_start_in),
    .ready_in(ready_in), .valid_out(valid_out), .x_out(x_out),
    .y_out(y_out), .z_out(z_out), .addr_out(addr_out),
    .clipped_out(clipped_out), .overflow_out(overflow_out),
    .vertex_count_out(vertex_count_out)
  );

  always #5 clk_in = ~clk_in;

  wire [64:0] head = {x_out, y_out, z_out, addr_out, clipped_out};

  // Reference: clamp to the screen, address = y*W + x, clipped if changed.
  function automatic logic [64:0] expv(int x, int y, int z);
    int cx, cy;
    cx = (x < 0) ? 0 : ((x > SW - 1) ? SW - 1 : x);
    cy = (y < 0) ? 0 : ((y > SH - 1) ? SH - 1 : y);
    return {16'(cx), 16'(cy), 16'(z), 16'(cy * SW + cx), (cx != x) || (cy != y)};
  endfunction

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic send(int w);
    data_valid_in = 1'b1;
    int_value_in  = 16'(w);
    step();
    data_valid_in = 1'b0;
  endtask

  task automatic frame();
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({valid_out, head, overflow_out, vertex_count_out} !== '0) begin
      n_err++;
      $display("FAIL reset: got v=%b head=%h ovf=%b cnt=%0d want all zero",
               valid_out, head, overflow_out, vertex_count_out);
    end
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ready_in = 1'b1;
    send(10); send(20); send(5);
    step();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL basic_latency: valid=%b want 0 one cycle after Z", valid_out);
    end
    step();
    n_cmp++;
    if ({valid_out, head, vertex_count_out} !== {1'b1, expv(10, 20, 5), 16'd1}) begin
      n_err++;
      $display("FAIL basic: got v=%b head=%h cnt=%0d want v=1 head=%h cnt=1",
               valid_out, head, vertex_count_out, expv(10, 20, 5));
    end
    step();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL basic_drain: valid=%b want 0", valid_out);
    end
  endtask

  task automatic test_clamp();
    int v[2][3] = '{'{-5, 200, 7}, '{400, 179, 0}};
    frame();
    ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(v[i][0]); send(v[i][1]); send(v[i][2]);
      step(); step();
      n_cmp++;
      if ({valid_out, head} !== {1'b1, expv(v[i][0], v[i][1], v[i][2])}) begin
        n_err++;
        $display("FAIL clamp%0d: got v=%b head=%h want head=%h",
                 i, valid_out, head, expv(v[i][0], v[i][1], v[i][2]));
      end
    end
    step();
  endtask

  task automatic test_overflow();
    frame();
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin send(i * 10); send(i * 7); send(i); end
    step(); step(); step();
    n_cmp++;
    if ({overflow_out, vertex_count_out} !== {1'b1, 16'd4}) begin
      n_err++;
      $display("FAIL overflow: got ovf=%b cnt=%0d want ovf=1 cnt=4", overflow_out, vertex_count_out);
    end
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({valid_out, head} !== {1'b1, expv(i * 10, i * 7, i)}) begin
        n_err++;
        $display("FAIL overflow_drain%0d: got v=%b head=%h want %h", i, valid_out, head, expv(i * 10, i * 7, i));
      end
      step();
    end
    n_cmp++;
    if ({valid_out, overflow_out} !== 2'b01) begin
      n_err++; $display("FAIL overflow_empty: got v=%b ovf=%b want v=0 ovf=1", valid_out, overflow_out);
    end
    frame();
    n_cmp++;
    if (overflow_out !== 1'b0) begin
      n_err++; $display("FAIL overflow_clear: got ovf=%b want 0", overflow_out);
    end
  endtask

  task automatic test_push_pop_full();
    frame();
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(i + 100); send(i + 50); send(i * 3);
      if (i == 4) begin
        step();               // push lands on the next edge: pop with it
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
      end
    end
    n_cmp++;
    if ({overflow_out, vertex_count_out} !== {1'b0, 16'd5}) begin
      n_err++;
      $display("FAIL pushpop: got ovf=%b cnt=%0d want ovf=0 cnt=5", overflow_out, vertex_count_out);
    end
    ready_in = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if ({valid_out, head} !== {1'b1, expv(i + 100, i + 50, i * 3)}) begin
        n_err++;
        $display("FAIL pushpop_drain%0d: got v=%b head=%h want %h", i, valid_out, head, expv(i + 100, i + 50, i * 3));
      end
      step();
    end
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL pushpop_occ: valid=%b want 0 after 4 pops", valid_out);
    end
  endtask

  task automatic test_frame_start();
    frame();
    ready_in = 1'b1;
    send(1); send(2);
    frame_start_in = 1'b1;
    send(30);
    frame_start_in = 1'b0;
    send(40); send(3);
    step(); step();
    n_cmp++;
    if ({valid_out, head, vertex_count_out} !== {1'b1, expv(30, 40, 3), 16'd1}) begin
      n_err++;
      $display("FAIL frame_start: got v=%b head=%h cnt=%0d want head=%h cnt=1",
               valid_out, head, vertex_count_out, expv(30, 40, 3));
    end
    step();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL frame_start_single: valid=%b want 0", valid_out);
    end
  endtask

  task automatic test_async_reset();
    frame();
    ready_in = 1'b0;
    send(11); send(22); send(33);
    send(44); send(55); send(66);
    step(); step(); step();
    n_cmp++;
    if ({valid_out, head} !== {1'b1, expv(11, 22, 33)}) begin
      n_err++; $display("FAIL areset_pre: got v=%b head=%h want %h", valid_out, head, expv(11, 22, 33));
    end
    #2 rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if ({valid_out, head, overflow_out, vertex_count_out} !== '0) begin
      n_err++;
      $display("FAIL areset: got v=%b head=%h ovf=%b cnt=%0d want all zero",
               valid_out, head, overflow_out, vertex_count_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step();
    ready_in = 1'b1;
    send(0); send(0); send(9);
    step(); step();
    n_cmp++;
    if ({valid_out, head, vertex_count_out} !== {1'b1, expv(0, 0, 9), 16'd1}) begin
      n_err++;
      $display("FAIL areset_after: got v=%b head=%h cnt=%0d want head=%h cnt=1",
               valid_out, head, vertex_count_out, expv(0, 0, 9));
    end
    step();
  endtask

  task automatic test_random();
    localparam int N = 30;
    logic [64:0] expq[N];
    logic [17:0] stream[$];   // [17] Z word, [16] valid, [15:0] data
    int w[3];
    int sent = 0;
    int rcv  = 0;
    frame();
    for (int v = 0; v < N; v++) begin
      w[0] = int'($urandom_range(0, 800)) - 200;
      w[1] = int'($urandom_range(0, 500)) - 150;
      w[2] = int'($urandom_range(0, 65535));
      expq[v] = expv(w[0], w[1], w[2]);
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(0, 2)) stream.push_back(18'd0);
        stream.push_back({k == 2, 1'b1, 16'(w[k])});
      end
    end
    for (int cyc = 0; cyc < 4000 && rcv < N; cyc++) begin
      data_valid_in = 1'b0;
      if (stream.size() > 0) begin
        logic [17:0] e;
        e = stream.pop_front();
        data_valid_in = e[16];
        int_value_in  = e[15:0];
        if (e[17]) sent++;
      end
      // keep backlog below FIFO depth so nothing is ever dropped
      ready_in = (sent - rcv >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk_in);
      if (valid_out && ready_in) begin
        n_cmp++;
        if (rcv >= sent || head !== expq[rcv]) begin
          n_err++;
          $display("FAIL random%0d: got head=%h want %h (sent=%0d)", rcv, head, expq[rcv], sent);
        end
        rcv++;
      end
      @(posedge clk_in); #1;
    end
    data_valid_in = 1'b0;
    n_cmp++;
    if ({rcv, overflow_out, vertex_count_out} !== {N, 1'b0, 16'(N)}) begin
      n_err++;
      $display("FAIL random_end: got rcv=%0d ovf=%b cnt=%0d want rcv=%0d ovf=0 cnt=%0d",
               rcv, overflow_out, vertex_count_out, N, N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_overflow();
    test_push_pop_full();
    test_frame_start();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vertex_assembler.md
# vertex_assembler

Downstream stage of the fp16-to-integer converter in the rendering pipeline. Collects the converter's serial integer output stream into (X, Y, Z) vertex triples. Clamps each vertex to screen bounds and computes its linear framebuffer address. Buffers completed vertices in a small FIFO with a valid/ready handshake toward the rasterizer.

## Interface
Parameters:
- SCREEN_W, 320, screen width in pixels
- SCREEN_H, 180, screen height in pixels
- DEPTH, 4, output FIFO depth in vertices (power of 2, ≥2)
- ADDR_W, 16, framebuffer address width

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- data_valid_in  input  1  int_value_in is valid this cycle
- int_value_in  input  16  converter output, interpreted as signed two's complement
- frame_start_in  input  1  synchronous pulse: restart word phase, clear frame status
- ready_in  input  1  downstream accepts the head vertex this cycle
- valid_out  output  1  FIFO non-empty; head vertex presented
- x_out  output  16  clamped X of head vertex
- y_out  output  16  clamped Y of head vertex
- z_out  output  16  Z of head vertex, unmodified
- addr_out  output  ADDR_W  y_out*SCREEN_W + x_out, truncated to ADDR_W
- clipped_out  output  1  head vertex had X or Y clamped
- overflow_out  output  1  sticky: a completed vertex was dropped because the FIFO was full
- vertex_count_out  output  16  vertices written to the FIFO since the last frame_start_in, saturating at 0xFFFF

## Operation
- Word phase counter: 0=X, 1=Y, 2=Z. Advances on each data_valid_in and wraps 2→0.
- Phase 0 and 1 words are latched into X and Y holding registers. A phase 2 word completes the vertex.
- Compute stage, one registered cycle:
  - x<0 → 0; x>SCREEN_W-1 → SCREEN_W-1.
  - Y is clamped the same way against SCREEN_H-1.
  - clipped = either clamp applied.
  - Address multiply uses the clamped values, then truncates to ADDR_W.
  - Z passes through unchanged.
- FIFO is first-word-fall-through. Outputs reflect the head entry combinationally from registers. Outputs hold their last value when empty; valid_out=0 when empty.
- Pop occurs when valid_out && ready_in.
- Push occurs when the compute stage holds a vertex.
  - If the FIFO is full and no pop occurs that cycle, the vertex is dropped: overflow_out←1 and vertex_count_out is not incremented.
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged.
- frame_start_in effects:
  - Phase←0, overflow_out←0, vertex_count_out←0.
  - A partially assembled vertex is discarded.
  - FIFO contents and any vertex already in the compute stage are preserved and delivered.
  - If a vertex push lands in the same cycle as frame_start_in, the push is not counted.
- frame_start_in with data_valid_in in the same cycle: the word is taken as X of the new frame, and phase becomes 1.

## Timing
- Reset (rst_n_in low, asynchronous): phase=0, compute stage empty, FIFO empty. valid_out, x_out, y_out, z_out, addr_out, clipped_out, overflow_out and vertex_count_out are all 0.
- Latency: Z word sampled at edge E0. Compute register loads at E1. FIFO write at E2. valid_out=1 from E2 if the FIFO was previously empty.
- Throughput: one vertex per 3 input words. Input has no backpressure; data_valid_in may be asserted every cycle.
- The compute stage never stalls. FIFO full is handled by dropping, never by blocking the input.
- Reset asserted mid-operation: all state is cleared immediately; partial vertices and FIFO contents are lost.
- overflow_out asserts in the cycle after the dropping edge and holds until frame_start_in or reset.
- vertex_count_out updates at the push edge E2.

## Test plan
- Basic vertex with ready_in=1:
  - Stimulus: words 10, 20, 5 on consecutive cycles.
  - Required: valid_out high 2 cycles after the Z word, with x=10, y=20, z=5, addr=6410, clipped=0, count=1.
- Clamping:
  - Stimulus: words -5 (0xFFFB), 200, 7.
  - Required: x=0, y=179, z=7, addr=57280, clipped=1.
  - Stimulus: words 400, 179, 0.
  - Required: x=319, addr=57599, clipped=1.
- Backpressure and overflow (ready_in=0, DEPTH=4):
  - Stimulus: 5 vertices.
  - Required: 4 stored, overflow_out=1, count=4.
  - Then ready_in=1: exactly the first 4 vertices drain in order, after which valid_out=0.
- Simultaneous push/pop at full:
  - Stimulus: FIFO holding 4 vertices, ready_in raised in the same cycle as a push.
  - Required: no overflow, occupancy stays 4, order preserved.
- frame_start mid-vertex:
  - Stimulus: words 1, 2, then frame_start_in together with word 30, then words 40, 3.
  - Required: one vertex (30, 40, 3), addr=12830, count=1.
- Asynchronous reset mid-stream:
  - Stimulus: drop rst_n_in between clock edges while the FIFO holds 2 vertices.
  - Required: all outputs 0 immediately.
  - After release, the next triple (0, 0, 9) yields addr=0, count=1.
